// File: rtl/eviction_buffer.sv
`default_nettype none
// ============================================================================
// Module      : eviction_buffer
// Description : Write-back FIFO for dirty cache lines. Accepts evicted lines
//               (merging into a matching queued entry when possible), drains
//               the oldest entry to physical memory over a write handshake,
//               and answers line lookups so misses to in-flight lines are
//               refilled with current data.
// Revision    : 1.0 - initial release
// ============================================================================
module eviction_buffer #(
    parameter int DEPTH = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             evict_req,
    input  logic [15:0]                      evict_addr,
    input  logic [127:0]                     evict_line,
    output logic                             evict_ack,
    input  logic                             drain_en,
    output logic                             pmem_write,
    output logic [15:0]                      pmem_address,
    output logic [127:0]                     pmem_wdata,
    input  logic                             pmem_resp,
    input  logic [15:0]                      lookup_addr,
    output logic                             lookup_hit,
    output logic [127:0]                     lookup_line,
    output logic                             empty,
    output logic                             full,
    output logic [$clog2(DEPTH+1)-1:0]       count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    // Entry storage
    logic [DEPTH-1:0]  r_valid;
    logic [11:0]       r_addr [DEPTH];
    logic [127:0]      r_line [DEPTH];

    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;
    state_t            r_state;

    logic              r_pmem_write;
    logic [15:0]       r_pmem_address;
    logic [127:0]      r_pmem_wdata;

    logic              w_merge_hit;
    logic [PW-1:0]     w_merge_idx;
    logic              w_lk_hit;
    logic [PW-1:0]     w_lk_idx;
    logic              w_full;
    logic              w_alloc;
    logic              w_merge_we;
    logic              w_pop;
    logic              w_unused;

    // Pointer arithmetic that wraps modulo DEPTH (DEPTH need not be a power of two)
    function automatic logic [PW-1:0] f_wrap(input logic [PW-1:0] base, input int off);
        int s;
        s = (int'(base) + off) % DEPTH;
        return PW'(s);
    endfunction

    // Low address bits select a word within the line and play no part here
    assign w_unused = ^{evict_addr[3:0], lookup_addr[3:0]};

    // Scan entries oldest to youngest so the last match found is the youngest.
    // The head being written to memory is never a merge target, so its
    // in-flight data stays frozen; lookup still sees it.
    always_comb begin
        logic [PW-1:0] idx;
        w_merge_hit = 1'b0;
        w_merge_idx = '0;
        w_lk_hit    = 1'b0;
        w_lk_idx    = '0;
        idx         = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = f_wrap(r_head, k);
            if (r_valid[idx] && (r_addr[idx] == evict_addr[15:4]) &&
                !((r_state == S_WRITE) && (idx == r_head))) begin
                w_merge_hit = 1'b1;
                w_merge_idx = idx;
            end
            if (r_valid[idx] && (r_addr[idx] == lookup_addr[15:4])) begin
                w_lk_hit = 1'b1;
                w_lk_idx = idx;
            end
        end
    end

    // Accept/merge/pop decisions; a full buffer refuses allocation even when
    // the head retires in the same cycle
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_merge_we = evict_req && w_merge_hit && !rst;
    assign w_alloc    = evict_req && !w_merge_hit && !w_full && !rst;
    assign w_pop      = (r_state == S_WRITE) && pmem_resp;
    assign evict_ack  = w_merge_we || w_alloc;

    // Entry payload: written on allocate at tail or merged in place
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_addr[r_tail] <= evict_addr[15:4];
            r_line[r_tail] <= evict_line;
        end else if (w_merge_we) begin
            r_line[w_merge_idx] <= evict_line;
        end
    end

    // Valid bits, FIFO pointers and occupancy count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_alloc) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= f_wrap(r_tail, 1);
            end
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= f_wrap(r_head, 1);
            end
            case ({w_alloc, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Drain FSM: latch the head into the memory port and hold it until
    // the write completes; always pass through IDLE between writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_pmem_write   <= 1'b0;
            r_pmem_address <= '0;
            r_pmem_wdata   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_valid[r_head] && drain_en) begin
                        r_state        <= S_WRITE;
                        r_pmem_write   <= 1'b1;
                        r_pmem_address <= {r_addr[r_head], 4'b0000};
                        r_pmem_wdata   <= r_line[r_head];
                    end
                end
                S_WRITE: begin
                    if (pmem_resp) begin
                        r_state        <= S_IDLE;
                        r_pmem_write   <= 1'b0;
                        r_pmem_address <= '0;
                        r_pmem_wdata   <= '0;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_pmem_write <= 1'b0;
                end
            endcase
        end
    end

    assign pmem_write   = r_pmem_write;
    assign pmem_address = r_pmem_address;
    assign pmem_wdata   = r_pmem_wdata;

    assign lookup_hit   = w_lk_hit;
    assign lookup_line  = w_lk_hit ? r_line[w_lk_idx] : 128'd0;

    assign count        = r_count;
    assign full         = w_full;
    assign empty        = (r_count == '0);

endmodule
`default_nettype wire

// File: tb/tb_eviction_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_eviction_buffer
// Description : Directed self-checking bench for eviction_buffer (DEPTH=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eviction_buffer;

    logic         clk;
    logic         rst;
    logic         evict_req;
    logic [15:0]  evict_addr;
    logic [127:0] evict_line;
    logic         evict_ack;
    logic         drain_en;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic         pmem_resp;
    logic [15:0]  lookup_addr;
    logic         lookup_hit;
    logic [127:0] lookup_line;
    logic         empty;
    logic         full;
    logic [1:0]   count;

    int r_total;
    int r_bad;

    localparam logic [127:0] c_LA = {16{8'hA5}};
    localparam logic [127:0] c_L1 = 128'h1111_0000_0000_0000_0000_0000_0000_0001;
    localparam logic [127:0] c_L2 = 128'h2222_0000_0000_0000_0000_0000_0000_0002;
    localparam logic [127:0] c_L3 = 128'h3333_0000_0000_0000_0000_0000_0000_0003;
    localparam logic [127:0] c_LB = {4{32'hBBBB_0001}};
    localparam logic [127:0] c_LC = {4{32'hCCCC_0002}};
    localparam logic [127:0] c_LD = {4{32'hDDDD_0003}};
    localparam logic [127:0] c_LE = {4{32'hEEEE_0004}};
    localparam logic [127:0] c_LF = {4{32'hFFFF_0005}};

    eviction_buffer #(.DEPTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .evict_req    (evict_req),
        .evict_addr   (evict_addr),
        .evict_line   (evict_line),
        .evict_ack    (evict_ack),
        .drain_en     (drain_en),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_resp    (pmem_resp),
        .lookup_addr  (lookup_addr),
        .lookup_hit   (lookup_hit),
        .lookup_line  (lookup_line),
        .empty        (empty),
        .full         (full),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        r_total++;
        if (got !== exp) begin
            r_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic evict(input logic [15:0] a, input logic [127:0] l);
        evict_req  = 1'b1;
        evict_addr = a;
        evict_line = l;
        #1;
    endtask

    initial begin
        r_total     = 0;
        r_bad       = 0;
        rst         = 1'b1;
        evict_req   = 1'b0;
        evict_addr  = '0;
        evict_line  = '0;
        drain_en    = 1'b0;
        pmem_resp   = 1'b0;
        lookup_addr = '0;
        step();
        step();
        rst = 1'b0;
        #1;

        // ---- reset state ----
        chk("rst_write", 128'(pmem_write), 128'd0);
        chk("rst_empty", 128'(empty), 128'd1);
        chk("rst_count", 128'(count), 128'd0);
        chk("rst_full",  128'(full), 128'd0);

        // ---- single drain ----
        drain_en = 1'b1;
        evict(16'h1230, c_LA);
        chk("sd_ack", 128'(evict_ack), 128'd1);
        step();
        evict_req = 1'b0;
        chk("sd_count1", 128'(count), 128'd1);
        chk("sd_nowrite_yet", 128'(pmem_write), 128'd0);
        step();
        chk("sd_write", 128'(pmem_write), 128'd1);
        chk("sd_addr", 128'(pmem_address), 128'h1230);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("sd_hold_wdata", pmem_wdata, c_LA);
            chk("sd_hold_write", 128'(pmem_write), 128'd1);
        end
        pmem_resp = 1'b1;
        step();
        pmem_resp = 1'b0;
        chk("sd_done_write", 128'(pmem_write), 128'd0);
        chk("sd_done_empty", 128'(empty), 128'd1);
        drain_en = 1'b0;

        // ---- fill / backpressure ----
        evict(16'h1000, c_L1);
        step();
        evict(16'h2000, c_L2);
        chk("fill_ack2", 128'(evict_ack), 128'd1);
        step();
        chk("fill_full", 128'(full), 128'd1);
        chk("fill_count", 128'(count), 128'd2);
        evict(16'h3000, c_L3);
        chk("fill_nack", 128'(evict_ack), 128'd0);
        step();
        evict_req = 1'b0;
        chk("fill_count_kept", 128'(count), 128'd2);
        lookup_addr = 16'h2008;
        #1;
        chk("fill_lk_hit", 128'(lookup_hit), 128'd1);
        chk("fill_lk_line", lookup_line, c_L2);
        lookup_addr = 16'h3000;
        #1;
        chk("fill_lk_miss", 128'(lookup_hit), 128'd0);
        chk("fill_lk_zero", lookup_line, 128'd0);
        // drain both; full blocks allocation even on the pop cycle
        drain_en = 1'b1;
        step();
        chk("fill_w1_addr", 128'(pmem_address), 128'h1000);
        pmem_resp = 1'b1;
        evict(16'h3000, c_L3);
        chk("fill_pop_nack", 128'(evict_ack), 128'd0);
        step();
        evict_req = 1'b0;
        pmem_resp = 1'b0;
        chk("fill_idle_gap", 128'(pmem_write), 128'd0);
        chk("fill_count_pop", 128'(count), 128'd1);
        step();
        chk("fill_w2_write", 128'(pmem_write), 128'd1);
        chk("fill_w2_addr", 128'(pmem_address), 128'h2000);
        chk("fill_w2_data", pmem_wdata, c_L2);
        pmem_resp = 1'b1;
        step();
        pmem_resp = 1'b0;
        drain_en  = 1'b0;
        chk("fill_empty", 128'(empty), 128'd1);

        // ---- merge ----
        evict(16'h4000, c_LB);
        step();
        evict(16'h400E, c_LC);
        chk("mg_ack", 128'(evict_ack), 128'd1);
        step();
        evict_req = 1'b0;
        chk("mg_count", 128'(count), 128'd1);
        lookup_addr = 16'h4000;
        #1;
        chk("mg_lk_line", lookup_line, c_LC);
        drain_en = 1'b1;
        step();
        chk("mg_wdata", pmem_wdata, c_LC);
        chk("mg_addr", 128'(pmem_address), 128'h4000);
        pmem_resp = 1'b1;
        step();
        pmem_resp = 1'b0;
        chk("mg_empty", 128'(empty), 128'd1);

        // ---- in-flight collision ----
        evict(16'h5000, c_LD);
        step();
        evict_req = 1'b0;
        step();
        chk("if_write", 128'(pmem_write), 128'd1);
        chk("if_wdata_d", pmem_wdata, c_LD);
        evict(16'h5000, c_LE);
        chk("if_ack", 128'(evict_ack), 128'd1);
        step();
        evict_req = 1'b0;
        chk("if_count2", 128'(count), 128'd2);
        chk("if_wdata_kept", pmem_wdata, c_LD);
        lookup_addr = 16'h5000;
        #1;
        chk("if_lk_young", lookup_line, c_LE);
        pmem_resp = 1'b1;
        step();
        pmem_resp = 1'b0;
        chk("if_gap", 128'(pmem_write), 128'd0);
        step();
        chk("if_next_write", 128'(pmem_write), 128'd1);
        chk("if_next_wdata", pmem_wdata, c_LE);
        pmem_resp = 1'b1;
        step();
        pmem_resp = 1'b0;
        chk("if_empty", 128'(empty), 128'd1);

        // ---- reset mid-WRITE ----
        evict(16'h6000, c_LF);
        step();
        evict_req = 1'b0;
        step();
        chk("rw_write", 128'(pmem_write), 128'd1);
        #2;
        rst = 1'b1;
        lookup_addr = 16'h6000;
        #1;
        chk("rw_write_clr", 128'(pmem_write), 128'd0);
        chk("rw_addr_clr", 128'(pmem_address), 128'd0);
        chk("rw_wdata_clr", pmem_wdata, 128'd0);
        chk("rw_count_clr", 128'(count), 128'd0);
        chk("rw_empty", 128'(empty), 128'd1);
        chk("rw_lk_clr", 128'(lookup_hit), 128'd0);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rw_no_reissue", 128'(pmem_write), 128'd0);
        end
        chk("rw_empty_after", 128'(empty), 128'd1);

        $display("test done: total=%0d bad=%0d", r_total, r_bad);
        $finish;
    end

endmodule
`default_nettype wire
